// File: rtl/alu_seq_ctrl_if.sv
// Request, response and ALU-side signals of the ALU sequencer.
// master = decode stage plus ALU; slave = the sequencer itself.
interface alu_seq_ctrl_if #(
  parameter int DATA_W = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [DATA_W-1:0]     req_a;
  logic [DATA_W-1:0]     req_b;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [2:0]            alu_funct;
  logic [DATA_W-1:0]     alu_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*DATA_W-1:0]   rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
    input  req_ready, alu_a, alu_b, alu_funct, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
    output req_ready, alu_a, alu_b, alu_funct, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencer driving the 8-bit ALU: SETUP/EXEC for simple ops, plus HI/LO reads for MUL/DIVMOD.
// Optional macro DIV_ZERO_CHK_EN short-circuits DIVMOD with b==0 into an error response.
module alu_seq_ctrl #(
  parameter int         DATA_W     = 8,
  parameter logic [2:0] IDLE_FUNCT = 3'b111,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_ctrl_if.slave    bus,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] FUNCT_HI = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EXEC,
    S_HI,
    S_LO,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic [2:0]            op_q, op_d;
  logic [2:0]            funct_q, funct_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [2*DATA_W-1:0]   data_q, data_d;
  logic                  err_q, err_d;
  logic                  vld_q, vld_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    funct_d = funct_q;
    hi_d    = hi_q;
    data_d  = data_q;
    err_d   = err_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          a_d  = bus.req_a;
          b_d  = bus.req_b;
          op_d = bus.req_op;
          // Illegal ops never touch the ALU: funct stays idle so nothing evaluates.
          if (bus.req_op >= 3'd6) begin
            state_d = S_RESP;
            vld_d   = 1'b1;
            data_d  = '0;
            err_d   = 1'b1;
          end
`ifdef DIV_ZERO_CHK_EN
          else if (bus.req_op == 3'd5 && bus.req_b == '0) begin
            state_d = S_RESP;
            vld_d   = 1'b1;
            data_d  = '1;
            err_d   = 1'b1;
          end
`endif
          else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        state_d = S_EXEC;
        funct_d = op_q;
      end
      S_EXEC: begin
        if (op_q >= 3'd4) begin
          state_d = S_HI;
          funct_d = FUNCT_HI;
        end else begin
          state_d = S_RESP;
          funct_d = IDLE_FUNCT;
          data_d  = {{DATA_W{1'b0}}, bus.alu_result};
          err_d   = 1'b0;
          vld_d   = 1'b1;
        end
      end
      S_HI: begin
        state_d = S_LO;
        hi_d    = bus.alu_result;
        funct_d = IDLE_FUNCT;
      end
      S_LO: begin
        state_d = S_RESP;
        data_d  = {hi_q, bus.alu_result};
        err_d   = 1'b0;
        vld_d   = 1'b1;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        funct_d = IDLE_FUNCT;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      funct_q <= IDLE_FUNCT;
      hi_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      funct_q <= funct_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_funct = funct_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a transaction-level reference model and an ALU model.
module tb_alu_seq_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] op_count;
  int          checks = 0;
  int          errors = 0;

  alu_seq_ctrl_if #(.DATA_W(8)) bus ();

  alu_seq_ctrl #(.DATA_W(8), .IDLE_FUNCT(3'b111), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // ALU: evaluates MUL/DIVMOD into hi/lo on the cycle funct selects them; 110/111 read them out.
  logic [7:0] alu_hi = 8'h00;
  logic [7:0] alu_lo = 8'h00;
  always @(posedge clk) begin
    if (bus.alu_funct == 3'd4)
      {alu_hi, alu_lo} <= {8'h00, bus.alu_a} * {8'h00, bus.alu_b};
    else if (bus.alu_funct == 3'd5)
      {alu_hi, alu_lo} <= (bus.alu_b == 8'h00) ? {bus.alu_a, 8'hFF}
                                               : {bus.alu_a % bus.alu_b, bus.alu_a / bus.alu_b};
  end
  always_comb begin
    bus.alu_result = 8'h00;
    case (bus.alu_funct)
      3'd0:    bus.alu_result = bus.alu_a & bus.alu_b;
      3'd1:    bus.alu_result = ~(bus.alu_a | bus.alu_b);
      3'd2:    bus.alu_result = bus.alu_a + bus.alu_b;
      3'd3:    bus.alu_result = bus.alu_a - bus.alu_b;
      3'd6:    bus.alu_result = alu_hi;
      3'd7:    bus.alu_result = alu_lo;
      default: bus.alu_result = 8'h00;
    endcase
  end

  // Transaction model: what a request must return and after how many cycles.
  task automatic model_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] d, output logic e, output int lat);
    logic [7:0] r;
    e = 1'b0;
    lat = 3;
    d = 16'h0000;
    case (op)
      3'd0: d = {8'h00, a & b};
      3'd1: d = {8'h00, ~(a | b)};
      3'd2: begin r = a + b; d = {8'h00, r}; end
      3'd3: begin r = a - b; d = {8'h00, r}; end
      3'd4: begin d = {8'h00, a} * {8'h00, b}; lat = 5; end
      3'd5: begin
        lat = 5;
        if (b == 8'h00) begin
`ifdef DIV_ZERO_CHK_EN
          d = 16'hFFFF; e = 1'b1; lat = 1;
`else
          d = {a, 8'hFF};
`endif
        end else begin
          d = {a % b, a / b};
        end
      end
      default: begin d = 16'h0000; e = 1'b1; lat = 1; end
    endcase
  endtask

  logic        m_busy = 0, m_vld = 0, m_short = 0;
  int          m_left = 0, m_phase = 0, m_lat = 0;
  logic [2:0]  m_op = 0;
  logic [7:0]  m_a = 0, m_b = 0;
  logic [15:0] m_d = 0, m_cnt = 0;
  logic        m_e = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_vld = 0; m_short = 0; m_left = 0; m_phase = 0;
      m_a = 0; m_b = 0; m_cnt = 0;
    end else if (m_vld) begin
      if (bus.rsp_ready) begin
        m_vld = 0; m_busy = 0; m_cnt = m_cnt + 16'd1;
      end
    end else if (m_busy) begin
      m_phase++;
      m_left--;
      if (m_left == 0) m_vld = 1;
    end else if (bus.req_valid) begin
      model_op(bus.req_op, bus.req_a, bus.req_b, m_d, m_e, m_lat);
      m_op = bus.req_op; m_a = bus.req_a; m_b = bus.req_b;
      m_busy = 1; m_phase = 1; m_short = (m_lat == 1); m_left = m_lat - 1;
      if (m_left == 0) m_vld = 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [2:0] ef;
    if (rst_n) begin
      ef = 3'b111;
      if (m_busy && !m_vld && !m_short) begin
        if (m_phase == 2) ef = m_op;
        else if (m_phase == 3 && m_op >= 3'd4) ef = 3'b110;
      end
      check("cyc_req_ready", bus.req_ready, !m_busy);
      check("cyc_rsp_valid", bus.rsp_valid, m_vld);
      check("cyc_op_count", op_count, m_cnt);
      check("cyc_alu_a", bus.alu_a, m_a);
      check("cyc_alu_b", bus.alu_b, m_b);
      check("cyc_alu_funct", bus.alu_funct, ef);
      if (m_vld) begin
        check("cyc_rsp_data", bus.rsp_data, m_d);
        check("cyc_rsp_err", bus.rsp_err, m_e);
      end
    end
  end

  task automatic do_op(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] ed, input logic ee, input int el, input int hold,
                       output logic [11:0] fseq);
    logic [2:0] f [1:12];
    int lat;
    for (int i = 1; i <= 12; i++) f[i] = 3'b000;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.rsp_ready = 1'b0;
    check({nm, "_ready_before"}, bus.req_ready, 1'b1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_op = 3'($urandom_range(0, 7));
    bus.req_a = 8'($urandom_range(0, 255));
    bus.req_b = 8'($urandom_range(0, 255));
    lat = 1;
    f[1] = bus.alu_funct;
    while (!bus.rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
      f[lat] = bus.alu_funct;
    end
    check({nm, "_latency"}, lat, el);
    check({nm, "_data"}, bus.rsp_data, ed);
    check({nm, "_err"}, bus.rsp_err, ee);
    for (int i = 0; i < hold; i++) begin
      bus.req_valid = 1'b1; bus.req_op = 3'd2;
      @(negedge clk);
      check({nm, "_hold_data"}, bus.rsp_data, ed);
      check({nm, "_hold_ready"}, bus.req_ready, 1'b0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({nm, "_valid_after_hs"}, bus.rsp_valid, 1'b0);
    fseq = {f[1], f[2], f[3], f[4]};
  endtask

  initial begin
    logic [11:0] fs;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_a = 8'h00; bus.req_b = 8'h00; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 16'h0000);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_funct", bus.alu_funct, 3'b111);
    check("rst_alu_a", bus.alu_a, 8'h00);
    check("rst_op_count", op_count, 16'd0);
    rst_n = 1'b1;

    do_op("add", 3'd2, 8'h7F, 8'h01, 16'h0080, 1'b0, 3, 0, fs);
    check("add_op_count", op_count, 16'd1);
    do_op("mul", 3'd4, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 5, 0, fs);
    check("mul_funct_seq", fs, 12'b111_100_110_111);
    do_op("divmod", 3'd5, 8'd200, 8'd7, 16'h041C, 1'b0, 5, 4, fs);
    do_op("illegal6", 3'd6, 8'h55, 8'hAA, 16'h0000, 1'b1, 1, 0, fs);
    check("illegal6_funct", fs[11:9], 3'b111);
    do_op("and", 3'd0, 8'hF0, 8'h3C, 16'h0030, 1'b0, 3, 1, fs);
    do_op("nor", 3'd1, 8'hF0, 8'h0C, 16'h0003, 1'b0, 3, 0, fs);
    do_op("sub", 3'd3, 8'h03, 8'h05, 16'h00FE, 1'b0, 3, 0, fs);
    do_op("illegal7", 3'd7, 8'h01, 8'h02, 16'h0000, 1'b1, 1, 0, fs);
`ifdef DIV_ZERO_CHK_EN
    do_op("div0", 3'd5, 8'h12, 8'h00, 16'hFFFF, 1'b1, 1, 0, fs);
`else
    do_op("div0", 3'd5, 8'h12, 8'h00, 16'h12FF, 1'b0, 5, 0, fs);
`endif
    check("op_count_9", op_count, 16'd9);

    // Abort a MUL while the high byte is being read.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd4; bus.req_a = 8'h10; bus.req_b = 8'h20;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_hi", bus.alu_funct, 3'b110);
    #2 rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", bus.rsp_valid, 1'b0);
    check("abort_funct", bus.alu_funct, 3'b111);
    check("abort_op_count", op_count, 16'd0);
    check("abort_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_stale", bus.rsp_valid, 1'b0);
    end
    do_op("add_after_rst", 3'd2, 8'h01, 8'h02, 16'h0003, 1'b0, 3, 0, fs);
    check("op_count_after_rst", op_count, 16'd1);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
